// File: rtl/strassen_result_drain_if.sv
// Result-write and element-stream bundle of the Strassen result drain.
// The slave modport is the drain itself; the master modport is its environment.
interface strassen_result_drain_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    // Stream handshake: an element transfers on every rising edge where out_valid
    // and out_ready are both high; once raised, out_valid stays high and out_data/
    // out_idx stay stable until that transfer, and out_valid never depends on out_ready.
    logic              wr_en;
    logic              wr_sel;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_idx;
    logic              out_last;
    logic              overflow;
    logic              proto_err;
    logic [CNT_W-1:0]  drop_cnt;
    logic              clear;
    logic [1:0]        fill_state;

    modport master (
        output wr_en, wr_sel, wr_data0, wr_data1, out_ready, clear,
        input  out_valid, out_data, out_idx, out_last, overflow, proto_err,
               drop_cnt, fill_state
    );

    modport slave (
        input  wr_en, wr_sel, wr_data0, wr_data1, out_ready, clear,
        output out_valid, out_data, out_idx, out_last, overflow, proto_err,
               drop_cnt, fill_state
    );
endinterface

// File: rtl/strassen_result_drain.sv
// Captures Strassen result pairs into two ping-pong banks and streams C11..C22
// row-major over a valid/ready port; frames arriving with both banks full are dropped.
module strassen_result_drain #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    strassen_result_drain_if.slave bus
);
    typedef enum logic [1:0] {WAIT_LO = 2'd0, WAIT_HI = 2'd1, DROP_HI = 2'd2} fill_e;
    typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2} bank_e;

    fill_e             fill_q, fill_d;
    logic              fill_bank_q, fill_bank_d;
    bank_e             bank_q [2];
    bank_e             bank_d [2];
    logic [DATA_W-1:0] mem_q  [2][4];
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        idx_q, idx_d;
    logic              overflow_q, overflow_d;
    logic              proto_q, proto_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic lo_free, lo_bank, wr_bank;
    logic do_lo, do_hi, do_drop, do_proto;
    logic valid, fire, last_fire;

    // Bank choice looks only at registered status, so a bank emptied on this edge is not reused yet.
    assign lo_free = (bank_q[0] != B_FULL) || (bank_q[1] != B_FULL);
    assign lo_bank = (bank_q[0] == B_FULL);
    assign wr_bank = (fill_q == WAIT_HI) ? fill_bank_q : lo_bank;

    // Fill FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q      <= WAIT_LO;
            fill_bank_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            fill_bank_q <= fill_bank_d;
        end
    end

    // Fill FSM: next state
    always_comb begin
        fill_d = fill_q;
        if (bus.wr_en) begin
            case (fill_q)
                WAIT_LO: if (!bus.wr_sel) fill_d = lo_free ? WAIT_HI : DROP_HI;
                WAIT_HI: if (bus.wr_sel)  fill_d = WAIT_LO;
                DROP_HI: begin
                    if (bus.wr_sel) fill_d = WAIT_LO;
                    else            fill_d = lo_free ? WAIT_HI : DROP_HI;
                end
                default: fill_d = WAIT_LO;
            endcase
        end
    end

    // Fill FSM: actions
    always_comb begin
        do_lo    = 1'b0;
        do_hi    = 1'b0;
        do_drop  = 1'b0;
        do_proto = 1'b0;
        if (bus.wr_en) begin
            case (fill_q)
                WAIT_LO: begin
                    if (bus.wr_sel)   do_proto = 1'b1;
                    else if (lo_free) do_lo    = 1'b1;
                    else              do_drop  = 1'b1;
                end
                WAIT_HI: begin
                    if (bus.wr_sel) do_hi = 1'b1;
                    else            do_lo = 1'b1;
                end
                DROP_HI: begin
                    if (!bus.wr_sel) begin
                        if (lo_free) do_lo   = 1'b1;
                        else         do_drop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        fill_bank_d = do_lo ? wr_bank : fill_bank_q;
    end

    assign valid     = (bank_q[rd_ptr_q] == B_FULL);
    assign fire      = valid && bus.out_ready;
    assign last_fire = fire && (idx_q == 2'd3);

    always_comb begin
        bank_d   = bank_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        if (fire) idx_d = last_fire ? 2'd0 : idx_q + 2'd1;
        if (last_fire) begin
            bank_d[rd_ptr_q] = B_EMPTY;
            rd_ptr_d         = ~rd_ptr_q;
        end
        if (do_lo) bank_d[wr_bank] = B_FILLING;
        if (do_hi) begin
            bank_d[wr_bank] = B_FULL;
            // With no older frame left queued, the newly completed bank is next to drain.
            if (bank_d[~wr_bank] != B_FULL) rd_ptr_d = wr_bank;
        end

        overflow_d = bus.clear ? 1'b0 : overflow_q;
        proto_d    = bus.clear ? 1'b0 : proto_q;
        cnt_d      = bus.clear ? '0 : cnt_q;
        if (do_proto) proto_d = 1'b1;
        if (do_drop) begin
            overflow_d = 1'b1;
            if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]  <= B_EMPTY;
            bank_q[1]  <= B_EMPTY;
            rd_ptr_q   <= 1'b0;
            idx_q      <= 2'd0;
            overflow_q <= 1'b0;
            proto_q    <= 1'b0;
            cnt_q      <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < 4; e++) mem_q[b][e] <= '0;
            end
        end else begin
            bank_q     <= bank_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            proto_q    <= proto_d;
            cnt_q      <= cnt_d;
            if (do_lo) begin
                mem_q[wr_bank][1] <= bus.wr_data0;
                mem_q[wr_bank][2] <= bus.wr_data1;
            end
            if (do_hi) begin
                mem_q[wr_bank][0] <= bus.wr_data0;
                mem_q[wr_bank][3] <= bus.wr_data1;
            end
        end
    end

    assign bus.out_valid  = valid;
    assign bus.out_data   = valid ? mem_q[rd_ptr_q][idx_q] : '0;
    assign bus.out_idx    = idx_q;
    assign bus.out_last   = valid && (idx_q == 2'd3);
    assign bus.overflow   = overflow_q;
    assign bus.proto_err  = proto_q;
    assign bus.drop_cnt   = cnt_q;
    assign bus.fill_state = fill_q;
endmodule

// File: tb/tb_strassen_result_drain.sv
// Bench for strassen_result_drain: frame table, drop/protocol/reset sequences,
// and a scoreboard that checks every accepted element against an expected queue.
`timescale 1ns/1ps
module tb_strassen_result_drain;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
    localparam int W      = DATA_W + 2;

    typedef struct {
        logic [DATA_W-1:0] lo0, lo1, hi0, hi1;
        logic [DATA_W-1:0] e11, e12, e21, e22;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rand_ready = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] exp_q[$];

    strassen_result_drain_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();
    strassen_result_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [DATA_W-1:0] c11, c12, c21, c22);
        exp_q.push_back({2'd0, c11});
        exp_q.push_back({2'd1, c12});
        exp_q.push_back({2'd2, c21});
        exp_q.push_back({2'd3, c22});
    endtask

    task automatic write_frame(input logic [DATA_W-1:0] lo0, lo1, hi0, hi1);
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data0 = lo0; bus.wr_data1 = lo1;
        tick();
        bus.wr_sel = 1'b1; bus.wr_data0 = hi0; bus.wr_data1 = hi1;
        tick();
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    // ---------------- scoreboard ----------------
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [1:0]        prev_idx;
    logic [W-1:0]      exp_beat;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!bus.out_valid || bus.out_data !== prev_data || bus.out_idx !== prev_idx) begin
                    errors++;
                    $display("FAIL stall_hold actual v=%0b idx=%0d data=%h required v=1 idx=%0d data=%h",
                             bus.out_valid, bus.out_idx, bus.out_data, prev_idx, prev_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected actual idx=%0d data=%h required no beat",
                             bus.out_idx, bus.out_data);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({bus.out_idx, bus.out_data} !== exp_beat ||
                        bus.out_last !== (exp_beat[W-1:W-2] == 2'd3)) begin
                        errors++;
                        $display("FAIL beat actual idx=%0d data=%h last=%0b required idx=%0d data=%h",
                                 bus.out_idx, bus.out_data, bus.out_last,
                                 exp_beat[W-1:W-2], exp_beat[DATA_W-1:0]);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_idx   = bus.out_idx;
        end
    end

    // ---------------- test sequence ----------------
    vec_t vecs [5];

    initial begin
        vecs[0] = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd7, 16'd5, 16'd6, 16'd8};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h0001};
        vecs[2] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h9ABC, 16'h1234, 16'h5678, 16'hDEF0};
        vecs[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 16'hC3C3, 16'h3C3C, 16'hC3C3, 16'hA5A5, 16'h5A5A, 16'h3C3C};

        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_data0 = '0; bus.wr_data1 = '0;
        bus.out_ready = 1'b1; bus.clear = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_data", 32'(bus.out_data), 32'd0);
        chk("rst_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_last", 32'(bus.out_last), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_proto", 32'(bus.proto_err), 32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single frames: latency, element order, bit-exactness
        for (int i = 0; i < 5; i++) begin
            push_frame(vecs[i].e11, vecs[i].e12, vecs[i].e21, vecs[i].e22);
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
            bus.wr_data0 = vecs[i].lo0; bus.wr_data1 = vecs[i].lo1;
            tick();
            @(negedge clk);
            chk("valid_after_lo", 32'(bus.out_valid), 32'd0);
            bus.wr_sel = 1'b1; bus.wr_data0 = vecs[i].hi0; bus.wr_data1 = vecs[i].hi1;
            tick();
            bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
            @(negedge clk);
            chk("first_beat_valid", 32'(bus.out_valid), 32'd1);
            chk("first_beat_data", 32'(bus.out_data), 32'(vecs[i].e11));
            wait_drain("table_frame");
        end

        // repeated low write overwrites C12/C21 of the same frame
        push_frame(16'd9, 16'd3, 16'd4, 16'd10);
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data0 = 16'd1; bus.wr_data1 = 16'd2;
        tick();
        bus.wr_data0 = 16'd3; bus.wr_data1 = 16'd4;
        tick();
        bus.wr_sel = 1'b1; bus.wr_data0 = 16'd9; bus.wr_data1 = 16'd10;
        tick();
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
        wait_drain("overwrite");

        // both banks full: drop, clear-vs-drop priority, then ordered drain
        bus.out_ready = 1'b0;
        push_frame(16'h0011, 16'h0012, 16'h0021, 16'h0022);
        write_frame(16'h0012, 16'h0021, 16'h0011, 16'h0022);
        push_frame(16'h1011, 16'h1012, 16'h1021, 16'h1022);
        write_frame(16'h1012, 16'h1021, 16'h1011, 16'h1022);
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data0 = 16'hEEE1; bus.wr_data1 = 16'hEEE2;
        tick();
        @(negedge clk);
        chk("drop_overflow", 32'(bus.overflow), 32'd1);
        chk("drop_cnt_1", 32'(bus.drop_cnt), 32'd1);
        chk("drop_state", 32'(bus.fill_state), 32'd2);
        bus.wr_sel = 1'b1; bus.wr_data0 = 16'hEEE3; bus.wr_data1 = 16'hEEE4;
        tick();
        bus.wr_sel = 1'b0; bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0; bus.wr_sel = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
        @(negedge clk);
        chk("clear_drop_overflow", 32'(bus.overflow), 32'd1);
        chk("clear_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("drop_held_c11", 32'(bus.out_data), 32'h0011);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        @(negedge clk);
        chk("clear_overflow", 32'(bus.overflow), 32'd0);
        chk("clear_cnt", 32'(bus.drop_cnt), 32'd0);
        bus.out_ready = 1'b1;
        wait_drain("two_banks");
        @(negedge clk);
        chk("idle_after_drain", 32'(bus.out_valid), 32'd0);

        // high write without a preceding low write
        tick();
        bus.wr_en = 1'b1; bus.wr_sel = 1'b1; bus.wr_data0 = 16'd3; bus.wr_data1 = 16'd4;
        tick();
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
        @(negedge clk);
        chk("proto_err_set", 32'(bus.proto_err), 32'd1);
        chk("proto_no_valid", 32'(bus.out_valid), 32'd0);
        chk("proto_state", 32'(bus.fill_state), 32'd0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        @(negedge clk);
        chk("proto_err_clear", 32'(bus.proto_err), 32'd0);
        tick();

        // free-running cadence: low write in cycle 2, high in cycle 3 of every 4
        fork
            begin : cad_drv
                logic [DATA_W-1:0] a, b, c, d;
                for (int f = 0; f < 16; f++) begin
                    a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
                    c = 16'($urandom_range(0, 65535)); d = 16'($urandom_range(0, 65535));
                    bus.wr_en = 1'b0;
                    tick();
                    tick();
                    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_data0 = a; bus.wr_data1 = b;
                    tick();
                    push_frame(c, a, b, d);
                    bus.wr_sel = 1'b1; bus.wr_data0 = c; bus.wr_data1 = d;
                    tick();
                end
                bus.wr_en = 1'b0; bus.wr_sel = 1'b0;
            end
            begin : cad_mon
                int w, gaps;
                w = 0;
                gaps = 0;
                while (!bus.out_valid && w < 100) begin
                    @(negedge clk);
                    w++;
                end
                chk("cadence_start", 32'(bus.out_valid), 32'd1);
                for (int i = 0; i < 64; i++) begin
                    if (!bus.out_valid) gaps++;
                    @(negedge clk);
                end
                chk("cadence_gaps", 32'(gaps), 32'd0);
            end
        join
        wait_drain("cadence");
        chk("cadence_drop_cnt", 32'(bus.drop_cnt), 32'd0);

        // asynchronous reset in the middle of a drain
        bus.out_ready = 1'b0;
        push_frame(16'd11, 16'd12, 16'd13, 16'd14);
        write_frame(16'd12, 16'd13, 16'd11, 16'd14);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("mid_drain_idx", 32'(bus.out_idx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_idx", 32'(bus.out_idx), 32'd0);
        exp_q.delete();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("no_residual", 32'(bus.out_valid), 32'd0);
        push_frame(16'd21, 16'd22, 16'd23, 16'd24);
        write_frame(16'd22, 16'd23, 16'd21, 16'd24);
        wait_drain("post_reset");

        // counter saturation under many drops, then random back-pressure
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.out_ready = 1'b0;
        push_frame(16'h0A11, 16'h0A12, 16'h0A21, 16'h0A22);
        write_frame(16'h0A12, 16'h0A21, 16'h0A11, 16'h0A22);
        push_frame(16'h0B11, 16'h0B12, 16'h0B21, 16'h0B22);
        write_frame(16'h0B12, 16'h0B21, 16'h0B11, 16'h0B22);
        for (int k = 0; k < 300; k++) begin
            write_frame(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                        16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
            if (k == 253) chk("cnt_254", 32'(bus.drop_cnt), 32'd254);
            if (k == 254) chk("cnt_255", 32'(bus.drop_cnt), 32'd255);
        end
        @(negedge clk);
        chk("sat_cnt", 32'(bus.drop_cnt), 32'd255);
        chk("sat_overflow", 32'(bus.overflow), 32'd1);
        tick();
        rand_ready = 1'b1;
        wait_drain("sat_drain");
        for (int k = 0; k < 6; k++) begin
            logic [DATA_W-1:0] a, b, c, d;
            a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535));
            c = 16'($urandom_range(0, 65535)); d = 16'($urandom_range(0, 65535));
            push_frame(c, a, b, d);
            write_frame(a, b, c, d);
            wait_drain("rand_ready_frame");
        end
        rand_ready = 1'b0;
        tick();
        bus.out_ready = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
